// File: rtl/bsg_miniblade_tag_packet_serializer.sv
// Serializes parallel bsg_tag packet requests onto the tag_clk/tag_data pair
// driving a miniblade pod's tag master, and raises a sticky done flag after the last packet.
module bsg_miniblade_tag_packet_serializer #(
  parameter int  tag_els_p      = 1024,
  parameter int  tag_lg_width_p = 4,
  parameter int  gap_bits_p     = 2,
  localparam int id_w_lp        = $clog2(tag_els_p),
  localparam int pmax_lp        = (1 << tag_lg_width_p) - 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [id_w_lp-1:0]        nodeid_i,
  input  logic                      data_not_reset_i,
  input  logic [tag_lg_width_p-1:0] len_i,
  input  logic [pmax_lp-1:0]        payload_i,
  input  logic                      last_i,
  output logic                      tag_clk_o,
  output logic                      tag_data_o,
  output logic                      tag_done_o
);

  localparam int hdr_w_lp = 2 + tag_lg_width_p + id_w_lp;
  localparam int sr_w_lp  = hdr_w_lp + pmax_lp;
  localparam int cnt_w_lp = $clog2(sr_w_lp + gap_bits_p + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 tag_clk_q, tag_clk_d;
  logic                 tag_data_q, tag_data_d;
  logic                 last_q, last_d;
  logic [sr_w_lp-1:0]   sr_q, sr_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [pmax_lp-1:0]   payload_masked;
  logic                 accept;
  logic                 tag_fall;
  logic                 busy;

  // Payload bits at or above len_i are forced to zero so they never reach the wire.
  for (genvar gi = 0; gi < pmax_lp; gi++) begin : g_mask
    assign payload_masked[gi] = payload_i[gi] & (len_i > tag_lg_width_p'(gi));
  end

  assign accept   = v_i & (state_q == IDLE);
  assign tag_fall = tag_clk_q;
  assign busy     = (state_q == SHIFT) | (state_q == GAP);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter covers frame plus gap bits; a final packet spends one extra
  // tag period in GAP (counter at zero) so done rises only when the gap ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT, GAP: begin
        if (tag_fall) begin
          if (cnt_q == cnt_w_lp'(0)) begin
            state_d = DONE;
          end else if ((cnt_q == cnt_w_lp'(1)) && !last_q) begin
            state_d = IDLE;
          end else if (cnt_q <= cnt_w_lp'(gap_bits_p)) begin
            state_d = GAP;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o    = (state_q == IDLE);
    tag_done_o = (state_q == DONE);
    tag_clk_o  = tag_clk_q;
    tag_data_o = tag_data_q;
  end

  always_comb begin
    tag_clk_d  = ~tag_clk_q;
    tag_data_d = tag_data_q;
    last_d     = last_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    if (accept) begin
      sr_d   = {payload_masked, nodeid_i, data_not_reset_i, len_i, 1'b1};
      cnt_d  = cnt_w_lp'(hdr_w_lp + gap_bits_p) + cnt_w_lp'(len_i);
      last_d = last_i;
    end else if (busy && tag_fall) begin
      // Zero-fill on shift so the gap bits come out of the register as 0.
      tag_data_d = sr_q[0];
      sr_d       = sr_q >> 1;
      if (cnt_q != cnt_w_lp'(0)) cnt_d = cnt_q - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_clk_q  <= 1'b0;
      tag_data_q <= 1'b0;
      last_q     <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      tag_clk_q  <= tag_clk_d;
      tag_data_q <= tag_data_d;
      last_q     <= last_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
